// File: rtl/drum_frame_sched_pkg.sv
// Shared types and constants for the drum mesh frame scheduler.
package drum_pkg;

   localparam int SAMPLE_W = 18;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TICK = 2'd1,
      RUN       = 2'd2,
      EMIT      = 2'd3
   } state_t;

   // Multiplier phases within one column: rho product, eta product, node update
   localparam logic [1:0] PH_RHO = 2'd0;
   localparam logic [1:0] PH_ETA = 2'd1;
   localparam logic [1:0] PH_UPD = 2'd2;

endpackage

// File: rtl/drum_frame_sched_if.sv
// Control, mesh-parameter, column-sweep and audio-stream signals of the frame scheduler.
interface drum_frame_sched_if
   import drum_pkg::*;
#(
   parameter int COL_W = 4
);
   logic             start;
   logic             stop;
   logic             strike;
   sample_t          strike_amp;
   sample_t          rho_in;
   sample_t          eta_in;
   sample_t          rho_q;
   sample_t          eta_q;
   logic [1:0]       node_phase;
   logic [COL_W-1:0] col_addr;
   logic             col_we;
   logic             strike_en;
   sample_t          strike_val;
   sample_t          sample_in;
   logic             audio_valid;
   sample_t          audio_data;
   logic             audio_ready;
   logic             busy;
   logic [7:0]       overrun_cnt;

   modport slave (
      input  start, stop, strike, strike_amp, rho_in, eta_in, sample_in, audio_ready,
      output rho_q, eta_q, node_phase, col_addr, col_we, strike_en, strike_val,
             audio_valid, audio_data, busy, overrun_cnt
   );

   modport master (
      output start, stop, strike, strike_amp, rho_in, eta_in, sample_in, audio_ready,
      input  rho_q, eta_q, node_phase, col_addr, col_we, strike_en, strike_val,
             audio_valid, audio_data, busy, overrun_cnt
   );

endinterface

// File: rtl/drum_frame_sched_tick.sv
// Audio sample-rate tick: counts 0..SAMPLE_DIV-1 while enabled and pulses tick on wrap.
module sample_tick_gen #(
   parameter int SAMPLE_DIV = 1042
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(SAMPLE_DIV);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(SAMPLE_DIV - 1));
   assign tick = en && wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/drum_frame_sched.sv
// Sweeps the waveguide mesh once per audio sample tick and streams the probe sample.
// Define DRUM_SCHED_OVERRUN_CNT_EN to count dropped ticks in overrun_cnt.
module drum_frame_sched
   import drum_pkg::*;
#(
   parameter int NCOLS      = 16,
   parameter int COL_W      = 4,
   parameter int SAMPLE_DIV = 1042
) (
   input logic               clk,
   input logic               reset,
   drum_frame_sched_if.slave bus
);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOLS - 1);

   state_t           state, next_state;
   logic [1:0]       phase;
   logic [COL_W-1:0] col_addr;
   sample_t          rho_q, eta_q, strike_val, audio_data;
   logic             strike_pending, frame_strike, stop_pending;
   logic             tick, tick_clr, busy, frame_start, last_upd, col_we;
   logic [7:0]       overrun_cnt;

   assign busy        = (state != IDLE);
   assign frame_start = (state == WAIT_TICK) && tick;
   assign col_we      = (state == RUN) && (phase == PH_UPD);
   assign last_upd    = col_we && (col_addr == LAST_COL);

   sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (tick_clr),
      .en    (busy),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // A stop seen in the accepting EMIT cycle ends the run just like an earlier one
   always_comb begin
      next_state = state;
      tick_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               next_state = WAIT_TICK;
               tick_clr   = 1'b1;
            end
         end
         WAIT_TICK: if (tick) next_state = RUN;
         RUN:       if (last_upd) next_state = EMIT;
         EMIT: begin
            if (bus.audio_ready) next_state = (stop_pending || bus.stop) ? IDLE : WAIT_TICK;
         end
         default:   next_state = IDLE;
      endcase
   end

   // The pending strike is consumed when a frame starts, so a strike landing mid-frame waits for the next one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase          <= PH_RHO;
         col_addr       <= '0;
         rho_q          <= '0;
         eta_q          <= '0;
         strike_val     <= '0;
         audio_data     <= '0;
         strike_pending <= 1'b0;
         frame_strike   <= 1'b0;
         stop_pending   <= 1'b0;
      end else begin
         if (frame_start) begin
            rho_q        <= bus.rho_in;
            eta_q        <= bus.eta_in;
            col_addr     <= '0;
            phase        <= PH_RHO;
            frame_strike <= strike_pending;
         end else if (state == RUN) begin
            phase <= (phase == PH_UPD) ? PH_RHO : phase + 2'd1;
            if (col_we && (col_addr != LAST_COL)) col_addr <= col_addr + COL_W'(1);
            if (last_upd) begin
               audio_data   <= bus.sample_in;
               frame_strike <= 1'b0;
            end
         end
         if (bus.strike) begin
            strike_pending <= 1'b1;
            strike_val     <= bus.strike_amp;
         end else if (frame_start) begin
            strike_pending <= 1'b0;
         end
         if (state == IDLE)  stop_pending <= 1'b0;
         else if (bus.stop)  stop_pending <= 1'b1;
      end
   end

`ifdef DRUM_SCHED_OVERRUN_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun_cnt <= '0;
      end else if (tick && (state != WAIT_TICK) && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end
`else
   assign overrun_cnt = '0;
`endif

   assign bus.rho_q       = rho_q;
   assign bus.eta_q       = eta_q;
   assign bus.node_phase  = phase;
   assign bus.col_addr    = col_addr;
   assign bus.col_we      = col_we;
   assign bus.strike_en   = col_we && frame_strike;
   assign bus.strike_val  = strike_val;
   assign bus.audio_valid = (state == EMIT);
   assign bus.audio_data  = audio_data;
   assign bus.busy        = busy;
   assign bus.overrun_cnt = overrun_cnt;

endmodule

// File: tb/tb_drum_frame_sched.sv
// Directed bench for drum_frame_sched with NCOLS=4, SAMPLE_DIV=20; cycle k counts clock edges after start.
module tb_drum_frame_sched;
   import drum_pkg::*;

   localparam int NCOLS      = 4;
   localparam int COL_W      = 2;
   localparam int SAMPLE_DIV = 20;

   logic clk;
   logic reset;
   int   vector_count;
   int   miss_count;

   drum_frame_sched_if #(.COL_W(COL_W)) bus ();

   drum_frame_sched #(
      .NCOLS      (NCOLS),
      .COL_W      (COL_W),
      .SAMPLE_DIV (SAMPLE_DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Data inputs follow the cycle index so latched values reveal when they were sampled
   task automatic applyStimulus(input int k);
      bus.sample_in = 18'(1000 + k);
      bus.rho_in    = 18'(500 + k);
      bus.eta_in    = 18'(2000 + k);
      @(negedge clk);
   endtask

   task automatic beginRun(input logic with_stop);
      bus.start = 1'b1;
      bus.stop  = with_stop;
      applyStimulus(-1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},    32'(bus.busy), 0);
      checkOutput({tag, "_col_we"},  32'(bus.col_we), 0);
      checkOutput({tag, "_str_en"},  32'(bus.strike_en), 0);
      checkOutput({tag, "_valid"},   32'(bus.audio_valid), 0);
      checkOutput({tag, "_data"},    32'(bus.audio_data), 0);
      checkOutput({tag, "_rho_q"},   32'(bus.rho_q), 0);
      checkOutput({tag, "_eta_q"},   32'(bus.eta_q), 0);
      checkOutput({tag, "_phase"},   32'(bus.node_phase), 0);
      checkOutput({tag, "_col"},     32'(bus.col_addr), 0);
      checkOutput({tag, "_str_val"}, 32'(bus.strike_val), 0);
      checkOutput({tag, "_overrun"}, 32'(bus.overrun_cnt), 0);
   endtask

   initial begin
      int   j;
      logic in_run, emit, exp_we;
      logic [7:0] exp_ovr;

      vector_count    = 0;
      miss_count      = 0;
      reset           = 1'b0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.strike      = 1'b0;
      bus.strike_amp  = '0;
      bus.sample_in   = '0;
      bus.rho_in      = '0;
      bus.eta_in      = '0;
      bus.audio_ready = 1'b1;
      #2;
      checkAllZero("rst0");
      @(negedge clk);
      reset = 1'b1;

      // Stop in IDLE must be ignored
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      @(negedge clk);
      checkOutput("idle_stop_busy", 32'(bus.busy), 0);

      // Frames at k=20,40,60; strike at 25 hits frame 40; stray start at 30; stop at 65
      $display("[TB] scenario: free-running frames, strike, stop");
      beginRun(1'b1);
      for (int k = 0; k <= 90; k++) begin
         j      = (k >= 20) ? (k - 20) % 20 : 99;
         in_run = (k >= 20) && (k <= 71) && (j < 12);
         emit   = (k >= 20) && (k <= 72) && (j == 12);
         exp_we = in_run && (j % 3 == 2);
         checkOutput("a_busy",   32'(bus.busy), 32'(k <= 72));
         checkOutput("a_col_we", 32'(bus.col_we), 32'(exp_we));
         checkOutput("a_str_en", 32'(bus.strike_en), 32'(exp_we && k >= 40 && k < 52));
         checkOutput("a_valid",  32'(bus.audio_valid), 32'(emit));
         if (in_run) begin
            checkOutput("a_phase", 32'(bus.node_phase), 32'(j % 3));
            checkOutput("a_col",   32'(bus.col_addr), 32'(j / 3));
         end
         if (emit) checkOutput("a_data", 32'(bus.audio_data), 32'(1000 + k - 1));
         if (k == 20 || k == 40 || k == 60) begin
            checkOutput("a_rho_q", 32'(bus.rho_q), 32'(500 + k - 1));
            checkOutput("a_eta_q", 32'(bus.eta_q), 32'(2000 + k - 1));
         end
         if (exp_we && k >= 40 && k < 52) checkOutput("a_str_val", 32'(bus.strike_val), 32'h3_0000);
         bus.strike     = (k == 25);
         bus.strike_amp = 18'h3_0000;
         bus.start      = (k == 30);
         bus.stop       = (k == 65);
         applyStimulus(k);
      end
      bus.strike = 1'b0;
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      checkOutput("a_overrun", 32'(bus.overrun_cnt), 0);

      // Sink stalls from RUN entry until k=49: one tick lands in EMIT
      $display("[TB] scenario: stalled sink");
      bus.audio_ready = 1'b0;
      beginRun(1'b0);
      for (int k = 0; k <= 80; k++) begin
         j      = (k >= 60) ? k - 60 : k - 20;
         in_run = ((k >= 20) && (k < 32)) || ((k >= 60) && (k < 72));
         emit   = ((k >= 32) && (k <= 49)) || (k == 72);
         exp_we = in_run && (j % 3 == 2);
`ifdef DRUM_SCHED_OVERRUN_CNT_EN
         exp_ovr = (k >= 40) ? 8'd1 : 8'd0;
`else
         exp_ovr = 8'd0;
`endif
         checkOutput("b_busy",    32'(bus.busy), 32'(k <= 72));
         checkOutput("b_col_we",  32'(bus.col_we), 32'(exp_we));
         checkOutput("b_str_en",  32'(bus.strike_en), 0);
         checkOutput("b_valid",   32'(bus.audio_valid), 32'(emit));
         checkOutput("b_overrun", 32'(bus.overrun_cnt), 32'(exp_ovr));
         if (emit && k < 50) checkOutput("b_data_hold", 32'(bus.audio_data), 32'(1031));
         if (k == 72)        checkOutput("b_data",      32'(bus.audio_data), 32'(1071));
         if (k == 60)        checkOutput("b_rho_q",     32'(bus.rho_q), 32'(559));
         bus.audio_ready = (k >= 49);
         bus.stop        = (k == 62);
         applyStimulus(k);
      end
      bus.stop = 1'b0;

      // Reset at RUN column 2 phase 1 with a strike pending
      $display("[TB] scenario: reset mid-frame");
      beginRun(1'b0);
      for (int k = 0; k <= 26; k++) begin
         bus.strike     = (k == 10);
         bus.strike_amp = 18'h1_2345;
         applyStimulus(k);
      end
      bus.strike = 1'b0;
      checkOutput("c_pre_col",   32'(bus.col_addr), 2);
      checkOutput("c_pre_phase", 32'(bus.node_phase), 1);
      reset = 1'b0;
      #1;
      checkAllZero("c_rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         checkOutput("c_idle_busy",   32'(bus.busy), 0);
         checkOutput("c_idle_col_we", 32'(bus.col_we), 0);
         checkOutput("c_idle_valid",  32'(bus.audio_valid), 0);
         applyStimulus(k);
      end

      // Discarded strike must not reach the next run's first frame
      beginRun(1'b0);
      for (int k = 0; k <= 33; k++) begin
         j      = k - 20;
         in_run = (k >= 20) && (k < 32);
         exp_we = in_run && (j % 3 == 2);
         checkOutput("d_col_we", 32'(bus.col_we), 32'(exp_we));
         checkOutput("d_str_en", 32'(bus.strike_en), 0);
         checkOutput("d_valid",  32'(bus.audio_valid), 32'(k == 32));
         applyStimulus(k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
